seq_mult: RTL
=============

// Module: seq_mult
//
// PURPOSE
//   Parametrised iterative shift-add multiplier with a command/busy/done handshake.
//   It replaces fixed-width two-bit multi-cycle multipliers in the datapath.
//   It retires one multiplier bit per cycle, supports unsigned and two's-complement
//   signed modes, and supports abort. Sits between the command decoder (func) and
//   result consumers, which sample out on done.
//
// PARAMETERS
//   WIDTH    4   operand width in bits; legal values 2..32; result is 2*WIDTH bits
//   CNT_W    $clog2(WIDTH)+1   iteration counter width; derived, do not override
//
// PORTS
//   clk    in   1          rising-edge clock
//   rst_n  in   1          asynchronous active-low reset
//   func   in   2          command: 0 = nop, 1 = unsigned mul, 2 = signed mul, 3 = abort
//   in1    in   WIDTH      multiplicand; sampled only on the accept edge
//   in2    in   WIDTH      multiplier; sampled only on the accept edge
//   out    out  2*WIDTH    registered product; holds until the next completion
//   busy   out  1          high while an operation is in flight
//   done   out  1          one-cycle pulse; out is valid in the same cycle
//
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, out=0, busy=0, done=0, cnt=0, accumulators=0.
//   States:
//     IDLE
//     RUN (cnt 0..WIDTH-1)
//   Accept: in IDLE with func==1 or func==2, the clock edge latches in1, in2 and the
//     mode. State goes to RUN and busy=1 from the next cycle.
//   RUN, each edge: if multiplier bit[cnt] is set, add the multiplicand shifted by cnt
//     into the 2*WIDTH accumulator. Then cnt++.
//   Signed mode:
//     - multiplicand is sign-extended to 2*WIDTH;
//     - the partial product of the multiplier MSB is subtracted, not added;
//     - the result is the exact two's-complement product.
//   Completion: on the edge where cnt==WIDTH-1:
//     - out <= final accumulator, done <= 1, busy <= 0;
//     - state <= IDLE, cnt <= 0.
//   Latency: done is high exactly WIDTH cycles after the accept edge.
//   done always deasserts on the following edge.
//   Back-to-back: a func==1 or func==2 presented in the done cycle is accepted, so the
//     issue rate is one operation per WIDTH+1 cycles.
//   func 1 or 2 while busy: ignored; operands are not re-sampled.
//   func==3 while busy: at the next edge state=IDLE, busy=0, cnt=0, and no done is
//     produced. out keeps its previous value.
//   func==3 in IDLE: no effect.
//   func==0 while busy: the operation continues.
//   Reset mid-operation: immediately returns to reset values; no done is produced.
//   Width rules:
//     - unsigned: out = in1*in2 < 2^(2*WIDTH), so no overflow is possible;
//     - signed: the most-negative times most-negative case fits in 2*WIDTH bits;
//     - intermediate sums wrap modulo 2^(2*WIDTH).
//   Inputs may change freely after the accept edge without affecting the result.
//
// TESTING  (WIDTH=4 unless noted)
//   1. func=1, in1=3, in2=2 -> done 4 cycles after accept, out=8'h06. Then
//      in1=15, in2=15 -> out=8'hE1.
//   2. func=2, in1=4'hD (-3), in2=4'h5 -> out=8'hF1 (-15). Then in1=4'h8, in2=4'h8
//      -> out=8'h40 (+64).
//   3. Back-to-back: issue the 2nd op in the done cycle -> it is accepted. Two done
//      pulses 5 cycles apart carry the correct results. Changing in1/in2 during RUN
//      has no effect on either result.
//   4. Abort: func=1, 6*7, then func=3 at cnt=2 -> busy=0 next cycle, no done, out
//      keeps the prior result. A new op then completes normally.
//   5. Async reset: pull rst_n low mid-RUN, between clock edges -> out, busy, done go
//      to 0 immediately. No spurious done after release.
//   6. WIDTH=2, func=1, in1=3, in2=3 -> out=4'h9 after 2 cycles. Random
//      signed/unsigned sweep at WIDTH=8 checked against a reference model.

Source files
------------

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier. One multiplier bit is retired per clock.
// Unsigned and two's-complement signed modes, with abort.
// A command is accepted from IDLE. The product appears on `out` together with
// a one-cycle `done` pulse, exactly WIDTH cycles after the accept edge.
module seq_mult #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           func,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = 2 * WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] FN_UMUL  = 2'd1;
  localparam logic [1:0] FN_SMUL  = 2'd2;
  localparam logic [1:0] FN_ABORT = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_mcand;   // multiplicand, pre-shifted left by r_cnt
  logic [WIDTH-1:0] r_mplier;  // multiplier, pre-shifted right by r_cnt
  logic             r_signed;
  logic [PW-1:0]    r_acc;

  logic             w_accept;
  logic             w_abort;
  logic             w_last;
  logic             w_sub;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_next;
  logic [PW-1:0]    w_mcand_ext;

  assign w_accept = (r_state == ST_IDLE) && ((func == FN_UMUL) || (func == FN_SMUL));
  assign w_abort  = (r_state == ST_RUN) && (func == FN_ABORT);
  assign w_last   = (r_cnt == LAST_CNT);

  // Shifting both operands each cycle avoids a variable bit-select on the
  // multiplier and a barrel shifter on the multiplicand.
  assign w_pp = r_mplier[0] ? r_mcand : '0;

  // In signed mode the multiplier MSB carries negative weight, so its
  // partial product is subtracted. Sums wrap modulo 2^PW, which gives the
  // exact product.
  assign w_sub      = r_signed && w_last;
  assign w_acc_next = w_sub ? (r_acc - w_pp) : (r_acc + w_pp);

  assign w_mcand_ext = (func == FN_SMUL) ? {{WIDTH{in1[WIDTH-1]}}, in1}
                                         : {{WIDTH{1'b0}}, in1};

  // Control FSM and datapath: accept, iterate, complete or abort.
  // NOTE: every register here uses non-blocking assignment, so all reads in
  // this block see the pre-edge values. The datapath registers are reset as
  // well, so `out` is defined from time zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_signed <= 1'b0;
      r_acc    <= '0;
      out      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mcand  <= w_mcand_ext;
            r_mplier <= in2;
            r_signed <= (func == FN_SMUL);
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_last) begin
            out     <= w_acc_next;
            r_acc   <= w_acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
